// File: rtl/wt_dcache_ship_pred_if.sv
// Bundles the miss, hit, fill and flush inputs and the prediction outputs
// that connect the SHiP insertion predictor to the dcache.
interface wt_dcache_ship_pred_if #(
    parameter int NUM_SETS  = 256,
    parameter int NUM_WAYS  = 4,
    parameter int SIG_WIDTH = 8
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                 flush_i;
    logic                 miss_req_i;
    logic [SIG_WIDTH-1:0] miss_sig_i;
    logic                 pred_valid_o;
    logic [1:0]           pred_result_o;
    logic                 fill_i;
    logic [IDX_W-1:0]     fill_idx_i;
    logic [WAY_W-1:0]     fill_way_i;
    logic [SIG_WIDTH-1:0] fill_sig_i;
    logic                 hit_i;
    logic [IDX_W-1:0]     hit_idx_i;
    logic [WAY_W-1:0]     hit_way_i;

    modport master (
        output flush_i, miss_req_i, miss_sig_i,
        output fill_i, fill_idx_i, fill_way_i, fill_sig_i,
        output hit_i, hit_idx_i, hit_way_i,
        input  pred_valid_o, pred_result_o
    );

    modport slave (
        input  flush_i, miss_req_i, miss_sig_i,
        input  fill_i, fill_idx_i, fill_way_i, fill_sig_i,
        input  hit_i, hit_idx_i, hit_way_i,
        output pred_valid_o, pred_result_o
    );
endinterface

// File: rtl/wt_dcache_ship_pred.sv
// SHiP-style insertion predictor: per-signature saturating counters trained by
// line reuse (hits) and dead evictions (fills over unreused lines).
module wt_dcache_ship_pred #(
    parameter int NUM_SETS  = 256,
    parameter int NUM_WAYS  = 4,
    parameter int SIG_WIDTH = 8,
    parameter int CTR_WIDTH = 3
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    wt_dcache_ship_pred_if.slave bus
);
    localparam int IDX_W      = $clog2(NUM_SETS);
    localparam int WAY_W      = $clog2(NUM_WAYS);
    localparam int LINE_W     = IDX_W + WAY_W;
    localparam int NUM_LINES  = NUM_SETS * NUM_WAYS;
    localparam int SHCT_DEPTH = 2 ** SIG_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1);

    logic [SHCT_DEPTH-1:0][CTR_WIDTH-1:0] shct_q;
    logic [NUM_LINES-1:0]                 valid_q, reuse_q;
    logic [NUM_LINES-1:0][SIG_WIDTH-1:0]  sig_q;
    logic                                 pred_valid_q;
    logic [1:0]                           pred_result_q, pred_result_d;

    logic [LINE_W-1:0]    hit_line, fill_line;
    logic [SIG_WIDTH-1:0] inc_sig, dec_sig;
    logic [CTR_WIDTH-1:0] miss_ctr;
    logic                 fill_upd, hit_upd, dead_evict, cancel, inc_en, dec_en;

    assign hit_line  = {bus.hit_idx_i, bus.hit_way_i};
    assign fill_line = {bus.fill_idx_i, bus.fill_way_i};
    assign inc_sig   = sig_q[hit_line];
    assign dec_sig   = sig_q[fill_line];

    // A fill to the line being hit replaces it, so that hit must not train.
    assign fill_upd   = bus.fill_i && !bus.flush_i;
    assign hit_upd    = bus.hit_i && !bus.flush_i && valid_q[hit_line]
                        && !(fill_upd && (fill_line == hit_line));
    assign dead_evict = fill_upd && valid_q[fill_line] && !reuse_q[fill_line];
    assign cancel     = hit_upd && dead_evict && (inc_sig == dec_sig);
    assign inc_en     = hit_upd && !cancel;
    assign dec_en     = dead_evict && !cancel;

    assign miss_ctr = shct_q[bus.miss_sig_i];

    always_comb begin
        pred_result_d = 2'd2;
        if (miss_ctr == '0)          pred_result_d = 2'd3;
        else if (miss_ctr == CTR_MAX) pred_result_d = 2'd1;
    end

    // inc and dec never target the same entry once cancel is applied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shct_q <= {SHCT_DEPTH{CTR_INIT}};
        end else begin
            if (inc_en && (shct_q[inc_sig] != CTR_MAX))
                shct_q[inc_sig] <= shct_q[inc_sig] + 1'b1;
            if (dec_en && (shct_q[dec_sig] != '0))
                shct_q[dec_sig] <= shct_q[dec_sig] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            reuse_q <= '0;
            sig_q   <= '0;
        end else if (bus.flush_i) begin
            valid_q <= '0;
            reuse_q <= '0;
        end else begin
            if (hit_upd) reuse_q[hit_line] <= 1'b1;
            if (fill_upd) begin
                valid_q[fill_line] <= 1'b1;
                reuse_q[fill_line] <= 1'b0;
                sig_q[fill_line]   <= bus.fill_sig_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q  <= 1'b0;
            pred_result_q <= 2'd2;
        end else begin
            pred_valid_q <= bus.miss_req_i;
            if (bus.miss_req_i) pred_result_q <= pred_result_d;
        end
    end

    assign bus.pred_valid_o  = pred_valid_q;
    assign bus.pred_result_o = pred_result_q;
endmodule

// File: doc/wt_dcache_ship_pred.md
# wt_dcache_ship_pred

Signature-based re-reference predictor for the write-through L1 dcache (SHiP-style). On every dcache miss it looks up a table of saturating counters indexed by the requester's signature and returns the 2-bit insertion RRPV that the SRRIP replacement unit applies to the incoming line. It learns from the cache's own hit and fill events: lines that are reused strengthen their signature, and lines evicted without reuse weaken it. It sits beside the dcache miss unit and drives the replacement unit's prediction input.

## Interface
- NUM_SETS, 256: cache sets (line index range).
- NUM_WAYS, 4: associativity.
- SIG_WIDTH, 8: signature width; SHCT depth = 2**SIG_WIDTH.
- CTR_WIDTH, 3: SHCT counter width; CTR_MAX = 2**CTR_WIDTH-1.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of per-line metadata (SHCT retained).
- miss_req_i  in  1  prediction request for a missing line.
- miss_sig_i  in  SIG_WIDTH  signature of the missing request (PC hash, computed upstream).
- pred_valid_o  out  1  prediction valid, one-cycle pulse.
- pred_result_o  out  2  predicted insertion RRPV.
- fill_i  in  1  line installed into the cache.
- fill_idx_i  in  $clog2(NUM_SETS)  set of the fill.
- fill_way_i  in  $clog2(NUM_WAYS)  victim way being overwritten.
- fill_sig_i  in  SIG_WIDTH  signature to record for the new line.
- hit_i  in  1  cache hit.
- hit_idx_i  in  $clog2(NUM_SETS)  set of the hit.
- hit_way_i  in  $clog2(NUM_WAYS)  way of the hit.

## Operation
- State:
  - SHCT: 2**SIG_WIDTH counters, each CTR_WIDTH bits.
  - Per-line metadata, NUM_SETS×NUM_WAYS entries, each holding {valid, reuse, sig}.
- Prediction:
  - Read ctr = SHCT[miss_sig_i].
  - ctr==0 -> RRPV 3 (distant).
  - ctr==CTR_MAX -> RRPV 1.
  - Otherwise -> RRPV 2.
- Hit training: when hit_i is asserted and line L = [hit_idx_i][hit_way_i] is valid:
  - Set reuse(L)=1.
  - Saturating-increment SHCT[sig(L)].
  - A hit to an invalid line is ignored.
- Fill training: when fill_i is asserted on line V = [fill_idx_i][fill_way_i]:
  - If valid(V)=1 and reuse(V)=0, saturating-decrement SHCT[sig(V)].
  - Then write V = {valid=1, reuse=0, sig=fill_sig_i}.
- Same-cycle hit and fill training the same SHCT entry: the +1 and -1 cancel, and the entry is unchanged.
- Same-cycle hit and fill on the same line: fill wins and the hit is dropped.
- Counters never wrap: increment at CTR_MAX and decrement at 0 leave the value unchanged.
- flush_i:
  - Clears valid and reuse of all lines at the next edge; sig is don't-care.
  - SHCT is untouched.
  - Events in the flush cycle are ignored.
  - A prediction requested in the flush cycle is still returned.

## Timing
- Reset values:
  - pred_valid_o=0.
  - pred_result_o=2'd2.
  - Every SHCT entry = 1.
  - All line valid=0, reuse=0, sig=0.
- Prediction latency is 1 cycle: miss_req_i at cycle t gives pred_valid_o=1 with pred_result_o at t+1.
  - pred_result_o holds its last value while pred_valid_o=0.
  - Back-to-back requests give back-to-back results.
- The SHCT read in cycle t sees the value before any update committed at the end of cycle t (read-old).
- Training from an event in cycle t is visible to a prediction requested at t+1.
- No handshake and no backpressure; the block accepts one miss, one hit and one fill per cycle.
- Reset asserted mid-operation:
  - All state returns to reset values asynchronously.
  - A pending pred_valid_o is dropped.

## Test plan
- Reset, then miss_req_i with sig 0x10 -> at t+1, pred_valid_o=1 and pred_result_o=2.
- Reuse saturation:
  - Stimulus: fill set 5 way 2 with sig 0x10, then 10 hits to set 5 way 2.
  - Response: SHCT[0x10]=7 and the next prediction for 0x10 returns 1.
- Dead-line training:
  - Stimulus: fill [3][0] with sig 0x22, then fill [3][0] again with sig 0x01 with no hit in between.
  - Response: SHCT[0x22] goes 1->0, and a prediction for 0x22 returns 3.
  - Stimulus: a further dead eviction of sig 0x22.
  - Response: the counter stays at 0.
- Cancel case:
  - Stimulus: in the same cycle, hit a line with sig 0x33 and fill over a dead line with sig 0x33.
  - Response: SHCT[0x33] is unchanged.
- Read-old:
  - Stimulus: in one cycle, miss_req_i sig 0x10 plus a hit on a line with sig 0x10, with SHCT[0x10]=6.
  - Response: result 2, and a request the next cycle returns 1.
- Flush and mid-operation reset:
  - Stimulus: flush_i, then fill [5][2].
  - Response: no decrement, because the line is invalid.
  - Stimulus: rst_ni dropped during a pending miss.
  - Response: pred_valid_o=0 and all counters = 1.
